// File: rtl/adc_seq_pkg.sv
// rtl/adc_seq_pkg.sv - shared types and widths for the ADC scan sequencer
package adc_seq_pkg;

    localparam int CH_W   = 5;
    localparam int DATA_W = 12;
    localparam int MAX_CH = 8;
    localparam int IDX_W  = $clog2(MAX_CH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        ISSUE,
        WAIT_RSP
    } state_t;

endpackage

// File: rtl/adc_seq_timer.sv
// rtl/adc_seq_timer.sv - scan-start tick generator, one pulse every SAMPLE_DIV cycles while run is high
module adc_seq_timer #(
    parameter int SAMPLE_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Dropping run reloads the count so a restart always waits a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RELOAD;
        end else if (!run || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = run && (cnt == '0);

endmodule

// File: rtl/adc_seq_ctrl.sv
// rtl/adc_seq_ctrl.sv - periodic ADC channel scan sequencer with sample buffer and sticky error flags
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_DIV = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     pll_locked,
    input  logic                     clr_flags,
    input  logic [NUM_CH*CH_W-1:0]   ch_list,
    output logic                     cmd_valid,
    output logic [CH_W-1:0]          cmd_channel,
    output logic                     cmd_sop,
    output logic                     cmd_eop,
    input  logic                     cmd_ready,
    input  logic                     rsp_valid,
    input  logic [CH_W-1:0]          rsp_channel,
    input  logic [DATA_W-1:0]        rsp_data,
    input  logic                     rsp_sop,
    input  logic                     rsp_eop,
    output logic                     smp_valid,
    output logic [CH_W-1:0]          smp_channel,
    output logic [DATA_W-1:0]        smp_data,
    output logic                     smp_last,
    input  logic                     smp_ready,
    output logic                     err_overrun,
    output logic                     err_mismatch,
    output logic                     err_missed_tick
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] index, index_next;
    logic             run, tick, stop_req, busy;
    logic             rsp_take, smp_load;
    logic [CH_W-1:0]  ch_sel;
    logic             unused_rsp_marks;

    assign run      = enable && pll_locked;
    assign busy     = (state == ISSUE) || (state == WAIT_RSP);
    assign rsp_take = rsp_valid && (state == WAIT_RSP);
    assign smp_load = rsp_take && (!smp_valid || smp_ready);

    // Framing marks on the response side carry nothing beyond the index we already track.
    assign unused_rsp_marks = rsp_sop ^ rsp_eop;

    adc_seq_timer #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    // stop_req remembers a stop seen mid-transaction so the scan ends after the in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            index    <= '0;
            stop_req <= 1'b0;
        end else begin
            state <= state_next;
            index <= index_next;
            if (state_next == IDLE) begin
                stop_req <= 1'b0;
            end else if (!run && busy) begin
                stop_req <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (tick) begin
                    state_next = ISSUE;
                    index_next = '0;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_valid) begin
                    if (stop_req || !run) begin
                        state_next = IDLE;
                        index_next = '0;
                    end else if (index == LAST_IDX) begin
                        state_next = WAIT_TICK;
                        index_next = '0;
                    end else begin
                        state_next = ISSUE;
                        index_next = index + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                index_next = '0;
            end
        endcase
    end

    always_comb begin
        cmd_valid = (state == ISSUE);
        cmd_sop   = (state == ISSUE) && (index == '0);
        cmd_eop   = (state == ISSUE) && (index == LAST_IDX);
    end

    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (index_next == IDX_W'(i)) begin
                ch_sel = ch_list[i*CH_W +: CH_W];
            end
        end
    end

    // The channel is captured on entry to ISSUE so it stays put even if ch_list moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_channel <= '0;
        end else if (state_next == ISSUE && state != ISSUE) begin
            cmd_channel <= ch_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_valid   <= 1'b0;
            smp_channel <= '0;
            smp_data    <= '0;
            smp_last    <= 1'b0;
        end else if (smp_load) begin
            smp_valid   <= 1'b1;
            smp_channel <= rsp_channel;
            smp_data    <= rsp_data;
            smp_last    <= (index == LAST_IDX);
        end else if (smp_valid && smp_ready) begin
            smp_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overrun     <= 1'b0;
            err_mismatch    <= 1'b0;
            err_missed_tick <= 1'b0;
        end else begin
            if (rsp_take && smp_valid && !smp_ready) begin
                err_overrun <= 1'b1;
            end else if (clr_flags) begin
                err_overrun <= 1'b0;
            end
            if (rsp_take && (rsp_channel != cmd_channel)) begin
                err_mismatch <= 1'b1;
            end else if (clr_flags) begin
                err_mismatch <= 1'b0;
            end
            if (tick && busy) begin
                err_missed_tick <= 1'b1;
            end else if (clr_flags) begin
                err_missed_tick <= 1'b0;
            end
        end
    end

endmodule
